// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared types and encodings for the CPU phase sequencer.
package cpu_seq_pkg;

  // Controller states; the eight datapath phases are contiguous.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REGRD  = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM    = 4'd5,
    S_WBRES  = 4'd6,
    S_WB     = 4'd7,
    S_PCUPD  = 4'd8,
    S_HALT   = 4'd9,
    S_FAULT  = 4'd10
  } state_e;

  // Phase numbers reported on the phase output.
  localparam logic [2:0] PH_FETCH  = 3'b000;
  localparam logic [2:0] PH_DECODE = 3'b001;
  localparam logic [2:0] PH_REGRD  = 3'b010;
  localparam logic [2:0] PH_EXEC   = 3'b011;
  localparam logic [2:0] PH_MEM    = 3'b100;
  localparam logic [2:0] PH_WBRES  = 3'b101;
  localparam logic [2:0] PH_WB     = 3'b110;
  localparam logic [2:0] PH_PCUPD  = 3'b111;

  // Fault causes.
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_STACK = 2'b01;
  localparam logic [1:0] FC_MEMTO = 2'b10;

  // One strobe per datapath phase.
  typedef struct packed {
    logic update_pc;
    logic writeback;
    logic wb_resolve;
    logic access_mem;
    logic execute;
    logic reg_read;
    logic decode;
    logic fetch;
  } strobe_t;

  // Phase number for a state; non-busy states report PH_FETCH (000).
  function automatic logic [2:0] phase_of(state_e s);
    logic [2:0] p;
    p = PH_FETCH;
    case (s)
      S_DECODE: p = PH_DECODE;
      S_REGRD:  p = PH_REGRD;
      S_EXEC:   p = PH_EXEC;
      S_MEM:    p = PH_MEM;
      S_WBRES:  p = PH_WBRES;
      S_WB:     p = PH_WB;
      S_PCUPD:  p = PH_PCUPD;
      default:  p = PH_FETCH;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// Handshake and status bundle between the datapath and the phase sequencer.
interface cpu_phase_sequencer_if;
  logic       run;
  logic       step;
  logic [7:0] instruction;
  logic [7:0] sp;
  logic       mem_r_en;
  logic       mem_w_en;
  logic       mem_ready;

  logic       fetch;
  logic       decode;
  logic       reg_read;
  logic       execute;
  logic       access_mem;
  logic       wb_resolve;
  logic       writeback;
  logic       update_pc;
  logic [2:0] phase;
  logic       busy;
  logic       halted;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] retired;

  // Datapath / test side: drives requests, observes strobes.
  modport master (
    output run, step, instruction, sp, mem_r_en, mem_w_en, mem_ready,
    input  fetch, decode, reg_read, execute, access_mem, wb_resolve,
           writeback, update_pc, phase, busy, halted, fault, fault_code, retired
  );

  // Sequencer side.
  modport slave (
    input  run, step, instruction, sp, mem_r_en, mem_w_en, mem_ready,
    output fetch, decode, reg_read, execute, access_mem, wb_resolve,
           writeback, update_pc, phase, busy, halted, fault, fault_code, retired
  );
endinterface

// File: rtl/cpu_phase_sequencer_wait_timer.sv
// Memory-wait counter: cleared outside MEM, counts stalled cycles inside it.
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);
  // term_o flags that the increment happening this cycle reaches MAX.
  localparam logic [7:0] MAX_M1 = 8'(MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  // Clear has priority; increment only when asked.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 8'd0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign term_o = inc_i && (cnt_q == MAX_M1);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Eight-phase instruction sequencer with memory-wait timeout, halt and
// stack-limit detection, free-run and single-step operation.
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter logic [7:0]  SP_LIMIT     = 8'h7F
) (
  input  logic clk,
  input  logic rst,
  cpu_phase_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic       run_q;
  logic       run_rise;
  logic       mem_act;
  logic [1:0] code_q, code_d;
  strobe_t    strobe_q, strobe_d;
  logic [2:0] phase_q, phase_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;
  logic [7:0] retired_q, retired_d;
  logic       tmr_clr, tmr_inc, tmr_term;

  assign run_rise = bus.run & ~run_q;
  assign mem_act  = bus.mem_r_en | bus.mem_w_en;
  // Counter is held at zero everywhere but MEM, so every MEM entry starts fresh.
  assign tmr_clr  = (state_q != S_MEM);

  seq_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .term_o (tmr_term)
  );

  // State, run-edge history and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      code_q    <= FC_NONE;
      strobe_q  <= '0;
      phase_q   <= PH_FETCH;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= bus.run;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Next-state: phase walk, memory handshake, halt/fault and loop decision.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tmr_inc = 1'b0;
    unique case (state_q)
      S_IDLE:   if (run_rise) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (bus.instruction == 8'h00) ? S_HALT : S_REGRD;
      S_REGRD:  state_d = S_EXEC;
      S_EXEC:   state_d = S_MEM;
      S_MEM: begin
        if (!mem_act || bus.mem_ready) begin
          state_d = S_WBRES;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_term) begin
            state_d = S_FAULT;
            code_d  = FC_MEMTO;
          end
        end
      end
      S_WBRES:  state_d = S_WB;
      S_WB:     state_d = S_PCUPD;
      S_PCUPD: begin
        // Stack check wins over any continue request.
        if (bus.sp < SP_LIMIT) begin
          state_d = S_FAULT;
          code_d  = FC_STACK;
        end else if (bus.step) begin
          state_d = S_IDLE;
        end else if (bus.run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    strobe_d = '0;
    case (state_d)
      S_FETCH:  strobe_d.fetch      = 1'b1;
      S_DECODE: strobe_d.decode     = 1'b1;
      S_REGRD:  strobe_d.reg_read   = 1'b1;
      S_EXEC:   strobe_d.execute    = 1'b1;
      S_MEM:    strobe_d.access_mem = mem_act;
      S_WBRES:  strobe_d.wb_resolve = 1'b1;
      S_WB:     strobe_d.writeback  = 1'b1;
      S_PCUPD:  strobe_d.update_pc  = 1'b1;
      default:  strobe_d = '0;
    endcase
    phase_d   = phase_of(state_d);
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT) && (state_d != S_FAULT);
    halted_d  = (state_d == S_HALT);
    fault_d   = (state_d == S_FAULT);
    retired_d = (state_q == S_PCUPD) ? retired_q + 8'd1 : retired_q;
  end

  assign bus.fetch      = strobe_q.fetch;
  assign bus.decode     = strobe_q.decode;
  assign bus.reg_read   = strobe_q.reg_read;
  assign bus.execute    = strobe_q.execute;
  assign bus.access_mem = strobe_q.access_mem;
  assign bus.wb_resolve = strobe_q.wb_resolve;
  assign bus.writeback  = strobe_q.writeback;
  assign bus.update_pc  = strobe_q.update_pc;
  assign bus.phase      = phase_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer with a phase-number reference model.
module tb_cpu_phase_sequencer;

  localparam int         MWM = 15;
  localparam logic [7:0] SPL = 8'h7F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_phase_sequencer_if bus();

  cpu_phase_sequencer #(.MEM_WAIT_MAX(MWM), .SP_LIMIT(SPL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_ph = -1 idle, 0..7 phase number, 8 halted, 9 faulted.
  int m_ph = -1, m_wait = 0, m_code = 0, m_ret = 0;
  bit m_runq = 1'b0, m_acc = 1'b0;

  // mem_ready responder: ready after rdy_delay stalled access cycles.
  int rdy_delay = 0, acc_run = 0;
  int busy_cnt = 0, acc_cnt = 0;
  int ph_log[$];

  function automatic logic [23:0] dut_vec();
    return {bus.update_pc, bus.writeback, bus.wb_resolve, bus.access_mem,
            bus.execute, bus.reg_read, bus.decode, bus.fetch,
            bus.phase, bus.busy, bus.halted, bus.fault, bus.fault_code, bus.retired};
  endfunction

  function automatic logic [23:0] model_vec();
    logic [7:0] s;
    logic [2:0] p;
    logic       b;
    s = 8'd0;
    p = 3'd0;
    b = 1'b0;
    if (m_ph >= 0 && m_ph <= 7) begin
      s[m_ph] = 1'b1;
      p = 3'(m_ph);
      b = 1'b1;
    end
    if (m_ph == 4 && !m_acc) s[4] = 1'b0;
    return {s, p, b, (m_ph == 8), (m_ph == 9), 2'(m_code), 8'(m_ret)};
  endfunction

  task automatic model_reset();
    m_ph = -1; m_wait = 0; m_code = 0; m_ret = 0; m_runq = 1'b0; m_acc = 1'b0;
  endtask

  // Advance the model with the inputs the DUT sampled at this edge.
  task automatic model_step();
    int nph;
    nph = m_ph;
    if (m_ph == -1) begin
      if (bus.run && !m_runq) nph = 0;
    end else if (m_ph == 1) begin
      nph = (bus.instruction == 8'h00) ? 8 : 2;
    end else if (m_ph == 3) begin
      m_wait = 0;
      nph = 4;
    end else if (m_ph == 4) begin
      if (!(bus.mem_r_en || bus.mem_w_en) || bus.mem_ready) nph = 5;
      else begin
        m_wait++;
        if (m_wait >= MWM) begin nph = 9; m_code = 2; end
      end
    end else if (m_ph == 7) begin
      m_ret = (m_ret + 1) % 256;
      if (bus.sp < SPL)   begin nph = 9; m_code = 1; end
      else if (bus.step)  nph = -1;
      else if (bus.run)   nph = 0;
      else                nph = -1;
    end else if (m_ph >= 0 && m_ph < 7) begin
      nph = m_ph + 1;
    end
    m_acc  = (nph == 4) && (bus.mem_r_en || bus.mem_w_en);
    m_ph   = nph;
    m_runq = bus.run;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // One clock: compare at the falling edge, respond on mem_ready, step the model.
  task automatic tick();
    logic [23:0] a, e;
    @(negedge clk);
    a = dut_vec();
    e = model_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle t=%0t dut=%h model=%h", $time, a, e);
    end
    if (bus.busy) begin busy_cnt++; ph_log.push_back(int'(bus.phase)); end
    if (bus.access_mem) begin acc_cnt++; acc_run++; end
    else acc_run = 0;
    bus.mem_ready = (acc_run > rdy_delay);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  // Run pulse: held two cycles, dropped mid-instruction, then n more cycles.
  task automatic run_pulse(input int n);
    bus.run = 1'b1;
    ticks(2);
    bus.run = 1'b0;
    ticks(n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, a0, l0;
    bus.run = 1'b0; bus.step = 1'b0; bus.instruction = 8'h15; bus.sp = 8'hFF;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.mem_ready = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_state", 32'(dut_vec()), 32'd0);
    ticks(2);
    rst = 1'b0;
    tick();

    // 1: plain instruction, no memory access
    b0 = busy_cnt; a0 = acc_cnt; l0 = ph_log.size();
    run_pulse(10);
    chk("t1_busy_cycles", busy_cnt - b0, 8);
    chk("t1_access_cycles", acc_cnt - a0, 0);
    for (int i = 0; i < 8; i++) chk("t1_phase_order", ph_log[l0 + i], i);
    chk("t1_retired", bus.retired, 1);
    chk("t1_idle", bus.busy, 0);

    // 2: read with three stalled cycles
    bus.mem_r_en = 1'b1; rdy_delay = 3;
    b0 = busy_cnt; a0 = acc_cnt;
    run_pulse(14);
    chk("t2_access_cycles", acc_cnt - a0, 4);
    chk("t2_busy_cycles", busy_cnt - b0, 11);
    chk("t2_retired", bus.retired, 2);

    // 3: write that never completes -> timeout fault
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b1; rdy_delay = 255;
    b0 = busy_cnt; a0 = acc_cnt;
    run_pulse(28);
    chk("t3_access_cycles", acc_cnt - a0, 15);
    chk("t3_fault", bus.fault, 1);
    chk("t3_fault_code", bus.fault_code, 2);
    chk("t3_busy", bus.busy, 0);
    chk("t3_retired", bus.retired, 2);
    b0 = busy_cnt;
    run_pulse(6);
    chk("t3_sticky_no_busy", busy_cnt - b0, 0);
    chk("t3_sticky_code", bus.fault_code, 2);
    do_reset();
    chk("t3_reset_clears", 32'(dut_vec()), 32'd0);
    bus.mem_w_en = 1'b0; rdy_delay = 0;

    // 4: all-zero instruction halts after decode
    bus.instruction = 8'h00;
    b0 = busy_cnt;
    run_pulse(6);
    chk("t4_busy_cycles", busy_cnt - b0, 2);
    chk("t4_halted", bus.halted, 1);
    chk("t4_retired", bus.retired, 0);
    b0 = busy_cnt;
    run_pulse(4);
    chk("t4_no_strobes", busy_cnt - b0, 0);
    do_reset();
    bus.instruction = 8'h15;

    // 5: stack pointer below the floor at PC update
    bus.sp = 8'h7E;
    run_pulse(12);
    chk("t5_retired", bus.retired, 1);
    chk("t5_fault", bus.fault, 1);
    chk("t5_fault_code", bus.fault_code, 1);
    do_reset();
    bus.sp = 8'hFF;

    // 6: single-step with run held high, then reset during execute
    bus.step = 1'b1;
    b0 = busy_cnt;
    bus.run = 1'b1;
    ticks(14);
    chk("t6_one_instr", busy_cnt - b0, 8);
    chk("t6_retired", bus.retired, 1);
    chk("t6_idle", bus.busy, 0);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    ticks(4);
    chk("t6_in_exec", {bus.execute, bus.phase}, {1'b1, 3'b011});
    #2 rst = 1'b1;
    model_reset();
    #1 chk("t6_async_reset", 32'(dut_vec()), 32'd0);
    bus.run = 1'b0; bus.step = 1'b0;
    tick();
    rst = 1'b0;
    b0 = busy_cnt;
    ticks(5);
    chk("t6_quiet_after_reset", busy_cnt - b0, 0);
    chk("t6_retired_zero", bus.retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Clocked controller that sequences the 8-bit multi-cycle CPU datapath through its eight phases: fetch, decode, register read, execute, memory access, writeback resolve, writeback, PC update. It replaces delay-driven phase stepping with one-cycle registered strobes. Memory access waits on a ready handshake with a timeout. The block detects halt (all-zero instruction) and stack-limit faults, and supports free-run and single-step operation.

Parameters:
MEM_WAIT_MAX, 15, maximum consecutive MEM cycles with mem_ready low before a timeout fault is raised (1..255).
SP_LIMIT, 8'h7F, stack pointer floor; an sp value below this at PC update is a fault.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
run  in  1  start/continue request (level; rising edge starts from IDLE)
step  in  1  1 = single-step mode
instruction  in  8  latched instruction word from the datapath
sp  in  8  current stack pointer (register 3)
mem_r_en  in  1  control-unit data-memory read enable
mem_w_en  in  1  control-unit data-memory write enable
mem_ready  in  1  data memory access complete
fetch  out  1  fetch strobe
decode  out  1  decode strobe
reg_read  out  1  register-file read strobe
execute  out  1  ALU execute strobe
access_mem  out  1  data-memory access strobe
wb_resolve  out  1  writeback source-select strobe
writeback  out  1  register write strobe
update_pc  out  1  PC update strobe
phase  out  3  current phase 3'b000..3'b111; 3'b000 when not busy
busy  out  1  1 while executing an instruction
halted  out  1  sticky halt flag
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 stack limit, 10 memory timeout
retired  out  8  retired-instruction counter, wraps 255->0

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all strobes, phase, busy, halted, fault, fault_code, retired and wait counter = 0; run edge register = 0.
- States: IDLE, FETCH, DECODE, REGRD, EXEC, MEM, WBRES, WB, PCUPD, HALT, FAULT.
- Outputs are Moore and registered. Each strobe is high exactly while the FSM is in its state. phase encodes FETCH=000 through PCUPD=111. busy = 1 in FETCH..PCUPD.
- IDLE -> FETCH on a run rising edge (run=1 with run_q=0). The fetch strobe is high on the first cycle after the edge is sampled.
- FETCH -> DECODE -> REGRD -> EXEC -> MEM -> WBRES -> WB -> PCUPD, one cycle each, except MEM.
- MEM: if mem_r_en|mem_w_en=0, stay one cycle with access_mem=0. Otherwise hold access_mem=1 until mem_ready=1 is sampled, then go to WBRES. The wait counter increments on each MEM cycle with mem_ready low. When it reaches MEM_WAIT_MAX, go to FAULT with code 10. The counter clears on MEM entry.
- Latency: 8 cycles per instruction with zero wait; each mem_ready-low cycle adds 1.
- DECODE: if instruction==8'h00, go to HALT instead of REGRD. retired is not incremented.
- PCUPD: retired += 1 (mod 256). Then, in priority order:
  1. sp < SP_LIMIT -> FAULT, code 01.
  2. step=1 -> IDLE.
  3. run=1 -> FETCH.
  4. else -> IDLE.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- HALT and FAULT are terminal until rst; run and step are ignored there. All strobes are 0 and busy=0. fault_code holds its value.
- Single-step mode requires a fresh run rising edge for each instruction.
- rst asserted mid-instruction aborts it; no strobes are emitted during or after reset until a new run edge.

Decomposition:
- Package cpu_seq_pkg: state enumeration (4-bit), phase encodings 3'b000..3'b111, fault code constants FC_NONE/FC_STACK/FC_MEMTO.
- One natural sub-module, seq_wait_timer: a clear/increment counter with a terminal flag at MEM_WAIT_MAX.

Test Plan:
- Reset, sp=8'hFF, instruction=8'h15, mem enables 0, run rises -> fetch..update_pc each high one cycle in order over 8 cycles; phase 0..7; retired=1; IDLE after run drops.
- mem_r_en=1, mem_ready low for 3 MEM cycles then high -> access_mem high 4 cycles; instruction takes 11 cycles; retired increments once.
- mem_w_en=1, mem_ready held 0 -> after 15 wait cycles fault=1, fault_code=10, all strobes 0, busy=0; stays there until rst.
- instruction=8'h00 -> cycle after DECODE halted=1, retired unchanged; a later run toggle causes no strobes.
- sp=8'h7E at PCUPD -> retired increments, then fault=1, fault_code=01.
- step=1 with run held high -> exactly one instruction, then IDLE; a run re-edge gives the next instruction. Assert rst during EXEC -> all outputs 0 asynchronously, retired=0.
